alu_sequencer: RTL and testbench

- Multi-cycle controller for the calculator arithmetic datapath. Accepts one command per start pulse, latches the operands and sequences the operation.
- ADD/SUB finish in a single cycle. MULT/DIV/MOD run on an iterative shift-add / restoring-divide engine over DATA_W cycles.
- Presents a registered 32-bit result and error flag, plus busy/done handshake, to the top-level board logic.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state and step-engine mode for the calculator ALU sequencer.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF  = 32;
  localparam int CNT_W_DEF  = 5;

  localparam logic [3:0] CMD_CLR  = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_MULT = 4'd3;
  localparam logic [3:0] CMD_DIV  = 4'd4;
  localparam logic [3:0] CMD_MOD  = 4'd5;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  typedef enum logic {MODE_MUL, MODE_DIV} mode_t;

  // Division by zero short-circuits to an error instead of iterating.
  function automatic logic is_iterative(input logic [3:0] cmd, input logic b_zero);
    return (cmd == CMD_MULT) || (((cmd == CMD_DIV) || (cmd == CMD_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// acc holds {high, low} halves: {partial product, multiplier} or {remainder, quotient}.
module muldiv_step
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic              mode,
  input  logic [RES_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [RES_W-1:0]  acc_next
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   trial;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    acc_next = '0;
    hi       = acc[RES_W-1:DATA_W];
    lo       = acc[DATA_W-1:0];
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    // Shifted remainder is below 2*divisor, so bit DATA_W of the difference is the borrow.
    trial    = {hi, lo[DATA_W-1]} - {1'b0, operand};
    if (mode == MODE_DIV) begin
      if (trial[DATA_W]) acc_next = {acc[RES_W-2:0], 1'b0};
      else               acc_next = {trial[DATA_W-1:0], lo[DATA_W-2:0], 1'b1};
    end else begin
      acc_next = {sum, lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer for the calculator datapath: single-cycle ADD/SUB/CLR,
// DATA_W-step iterative MULT/DIV/MOD, registered result/error with busy/done.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        command,
  input  logic [DATA_W-1:0] inputA,
  input  logic [DATA_W-1:0] inputB,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic              error
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op;
  logic [DATA_W-1:0] operand;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  acc_next;
  logic [RES_W-1:0]  iter_result;
  logic              mode;

  logic              sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] as_sum;
  logic              as_ovf;

  // ADD/SUB share one adder: SUB is A + ~B + 1, overflow when like-signed inputs give an unlike-signed sum.
  always_comb begin
    sub    = (command == CMD_SUB);
    b_eff  = sub ? ~inputB : inputB;
    as_sum = inputA + b_eff + DATA_W'(sub);
    as_ovf = (inputA[DATA_W-1] == b_eff[DATA_W-1]) && (as_sum[DATA_W-1] != inputA[DATA_W-1]);
  end

  assign mode = (op == CMD_MULT) ? MODE_MUL : MODE_DIV;

  muldiv_step #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_comb begin
    iter_result = acc_next;
    if (op == CMD_DIV)      iter_result = RES_W'(acc_next[DATA_W-1:0]);
    else if (op == CMD_MOD) iter_result = RES_W'(acc_next[RES_W-1:DATA_W]);
  end

  // NOTE: all state, including the operand and accumulator registers, is cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= CMD_CLR;
      operand <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            op      <= command;
            operand <= inputB;
            acc     <= RES_W'(inputA);
            cnt     <= '0;
            busy    <= 1'b1;
            if (is_iterative(command, inputB == '0)) begin
              state <= ITER;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              case (command)
                CMD_CLR: begin
                  result <= '0;
                  error  <= 1'b0;
                end
                CMD_ADD, CMD_SUB: begin
                  result <= {{(RES_W-DATA_W){as_sum[DATA_W-1]}}, as_sum};
                  error  <= as_ovf;
                end
                default: begin
                  result <= '0;
                  error  <= 1'b1;
                end
              endcase
            end
          end
        end
        ITER: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= iter_result;
            error  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;

  localparam int DW       = 16;
  localparam int RW       = 32;
  localparam int ITER_LAT = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    command;
  logic [DW-1:0] inputA;
  logic [DW-1:0] inputB;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          error;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(
    .DATA_W (DW),
    .RES_W  (RW),
    .CNT_W  (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .command (command),
    .inputA  (inputA),
    .inputB  (inputB),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Reference: {error, result} from plain integer arithmetic.
  function automatic logic [RW:0] model(input logic [3:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int            s;
    logic [DW-1:0] w;
    logic [RW-1:0] prod;
    case (cmd)
      4'd0: return '0;
      4'd1, 4'd2: begin
        s = (cmd == 4'd1) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
        w = s[DW-1:0];
        return {(s > 32767) || (s < -32768), {(RW-DW){w[DW-1]}}, w};
      end
      4'd3: begin
        prod = RW'(a) * RW'(b);
        return {1'b0, prod};
      end
      4'd4: return (b == 0) ? {1'b1, {RW{1'b0}}} : {1'b0, RW'(a / b)};
      4'd5: return (b == 0) ? {1'b1, {RW{1'b0}}} : {1'b0, RW'(a % b)};
      default: return {1'b1, {RW{1'b0}}};
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] cmd, input logic [DW-1:0] b);
    if (cmd == 4'd3 || ((cmd == 4'd4 || cmd == 4'd5) && b != 0)) return ITER_LAT;
    return 1;
  endfunction

  // Issues one command from an idle DUT, returns what was observed at done and one cycle later.
  task automatic do_cmd(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [RW-1:0] res, output logic err, output int lat,
                        output int bcyc, output bit idle_after);
    command = c; inputA = a; inputB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    command = 4'($urandom);
    inputA  = DW'($urandom);
    inputB  = DW'($urandom);
    lat = 0; bcyc = 0; res = '0; err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
      if (done) begin
        res = result;
        err = error;
        break;
      end
    end
    @(negedge clk);
    idle_after = !busy && !done && (result === res) && (error === err);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; command = '0; inputA = '0; inputB = '0;
    #12;
    checks++;
    if ({busy, done, error, result} !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%0b done=%0b error=%0b result=%h expected all zero", busy, done, error, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0]    cv[14] = '{1, 2, 1, 2, 3, 3, 4, 5, 4, 5, 9, 0, 4, 15};
    logic [DW-1:0] av[14] = '{255, 100, 16'h7FFF, 16'h8000, 255, 16'hFFFF, 1000, 1000, 1000, 1234, 5, 77, 16'hFFFF, 3};
    logic [DW-1:0] bv[14] = '{127, 200, 1, 1, 127, 16'hFFFF, 7, 7, 0, 0, 5, 88, 1, 4};
    logic [RW-1:0] res;
    logic          err;
    int            lat, bcyc;
    bit            idle;
    logic [RW:0]   exp;
    for (int i = 0; i < 14; i++) begin
      do_cmd(cv[i], av[i], bv[i], res, err, lat, bcyc, idle);
      exp = model(cv[i], av[i], bv[i]);
      checks += 4;
      if (res !== exp[RW-1:0] || err !== exp[RW]) begin
        failures++;
        $display("FAIL directed[%0d] cmd=%0d result/error got %h/%0b expected %h/%0b", i, cv[i], res, err, exp[RW-1:0], exp[RW]);
      end
      if (lat != model_lat(cv[i], bv[i])) begin
        failures++;
        $display("FAIL directed[%0d] latency got %0d expected %0d", i, lat, model_lat(cv[i], bv[i]));
      end
      if (bcyc != model_lat(cv[i], bv[i])) begin
        failures++;
        $display("FAIL directed[%0d] busy_cycles got %0d expected %0d", i, bcyc, model_lat(cv[i], bv[i]));
      end
      if (!idle) begin
        failures++;
        $display("FAIL directed[%0d] return_to_idle got busy=%0b done=%0b expected 0/0 with result held", i, busy, done);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]    c;
    logic [DW-1:0] a, b;
    logic [RW-1:0] res;
    logic          err;
    int            lat, bcyc;
    bit            idle;
    logic [RW:0]   exp;
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      a = DW'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      do_cmd(c, a, b, res, err, lat, bcyc, idle);
      exp = model(c, a, b);
      checks += 2;
      if (res !== exp[RW-1:0] || err !== exp[RW]) begin
        failures++;
        $display("FAIL random[%0d] cmd=%0d a=%h b=%h got %h/%0b expected %h/%0b", i, c, a, b, res, err, exp[RW-1:0], exp[RW]);
      end
      if (lat != model_lat(c, b) || !idle) begin
        failures++;
        $display("FAIL random[%0d] timing latency=%0d idle_after=%0b expected %0d/1", i, lat, idle, model_lat(c, b));
      end
    end
  endtask

  // Disturb start/command/inputA during a MULT; the run must complete as if undisturbed.
  task automatic test_ignore_start();
    logic [RW-1:0] res;
    logic          err;
    int            lat, bcyc;
    bit            idle, seen;
    do_cmd(4'd1, 16'd10, 16'd20, res, err, lat, bcyc, idle);
    command = 4'd3; inputA = 16'd255; inputB = 16'd127; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (result !== 32'd30 || error !== 1'b0) begin
          failures++;
          $display("FAIL hold_during_iter result got %h/%0b expected %h/0", result, error, 32'd30);
        end
      end
      if (i == 5) begin start = 1'b1; command = 4'd1; inputA = 16'd1; end
      if (i == 7) start = 1'b0;
      if (done) begin seen = 1'b1; lat = i; res = result; end
    end
    checks += 3;
    if (lat != ITER_LAT) begin
      failures++;
      $display("FAIL ignore_start latency got %0d expected %0d", lat, ITER_LAT);
    end
    if (res !== 32'd32385) begin
      failures++;
      $display("FAIL ignore_start result got %h expected %h", res, 32'd32385);
    end
    @(negedge clk);
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start not_queued busy got %0b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] res;
    logic          err;
    int            lat, bcyc;
    bit            idle;
    do_cmd(4'd1, 16'd40, 16'd2, res, err, lat, bcyc, idle);
    command = 4'd4; inputA = 16'd1000; inputB = 16'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, result} !== '0) begin
      failures++;
      $display("FAIL reset_mid_div busy=%0b done=%0b error=%0b result=%h expected all zero", busy, done, error, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(4'd1, 16'd2, 16'd3, res, err, lat, bcyc, idle);
    checks++;
    if (res !== 32'd5 || err !== 1'b0 || lat != 1 || !idle) begin
      failures++;
      $display("FAIL add_after_reset got %h/%0b latency %0d expected %h/0 latency 1", res, err, lat, 32'd5);
    end
  endtask

  // start held high: one acceptance every latency+1 cycles.
  task automatic test_back_to_back(input logic [3:0] c, input int window, input int exp_pulses);
    logic [DW-1:0] a, b;
    logic [RW:0]   exp;
    int            pulses;
    a = DW'($urandom); b = DW'($urandom_range(1, 65535));
    exp = model(c, a, b);
    command = c; inputA = a; inputB = b; start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        checks++;
        if (result !== exp[RW-1:0] || error !== exp[RW]) begin
          failures++;
          $display("FAIL back_to_back cmd=%0d pulse %0d got %h/%0b expected %h/%0b", c, pulses, result, error, exp[RW-1:0], exp[RW]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != exp_pulses) begin
      failures++;
      $display("FAIL back_to_back cmd=%0d done_pulses got %0d expected %0d", c, pulses, exp_pulses);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back(4'd1, 20, 10);
    test_back_to_back(4'd3, 2 * (ITER_LAT + 1), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
